// File: rtl/snoop_responder_if.sv
// snoop_responder_if: snoop request, tag-store lookup/update, writeback and result signals.
interface snoop_responder_if #(
  parameter int indexBits = 14,
  parameter int tagBits = 12,
  parameter int ways = 8,
  parameter int countBits = 16
);
  localparam int wayBits = $clog2(ways);
  logic snoopValid;
  logic snoopReady;
  logic [1:0] snoopOp;
  logic [31:0] snoopAddress;
  logic lookupValid;
  logic [indexBits-1:0] lookupIndex;
  logic [tagBits-1:0] lookupTag;
  logic lookupDone;
  logic lookupHit;
  logic [wayBits-1:0] lookupWay;
  logic [1:0] lookupMesi;
  logic updateValid;
  logic [indexBits-1:0] updateIndex;
  logic [wayBits-1:0] updateWay;
  logic [1:0] updateMesi;
  logic wbValid;
  logic wbReady;
  logic [indexBits-1:0] wbIndex;
  logic [wayBits-1:0] wbWay;
  logic resultValid;
  logic [1:0] snoopResult;
  logic protocolError;
  logic [countBits-1:0] hitCount;
  logic [countBits-1:0] hitmCount;
  modport master (
    output snoopValid, snoopOp, snoopAddress, lookupDone, lookupHit, lookupWay, lookupMesi, wbReady,
    input snoopReady, lookupValid, lookupIndex, lookupTag, updateValid, updateIndex, updateWay,
    updateMesi, wbValid, wbIndex, wbWay, resultValid, snoopResult, protocolError, hitCount, hitmCount
  );
  modport slave (
    input snoopValid, snoopOp, snoopAddress, lookupDone, lookupHit, lookupWay, lookupMesi, wbReady,
    output snoopReady, lookupValid, lookupIndex, lookupTag, updateValid, updateIndex, updateWay,
    updateMesi, wbValid, wbIndex, wbWay, resultValid, snoopResult, protocolError, hitCount, hitmCount
  );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: answers one bus snoop at a time against the MESI tag store, writing back dirty lines.
module snoop_responder #(
  parameter int indexBits = 14,
  parameter int tagBits = 12,
  parameter int ways = 8,
  parameter int countBits = 16
) (
  input logic clk,
  input logic reset,
  snoop_responder_if.slave bus
);
  localparam int wayBits = $clog2(ways);
  typedef enum logic [2:0] {IDLE, LOOKUP, DECIDE, WRITEBACK, UPDATE, RESPOND} state_t;
  state_t state, nextState;
  logic [1:0] op, mesi, newMesi, result, decideResult, decideMesi;
  logic [indexBits-1:0] index;
  logic [tagBits-1:0] tag;
  logic [wayBits-1:0] way;
  logic hit, lineValid, decideError, unusedOffset;
  logic [countBits-1:0] hitCount, hitmCount;
  assign unusedOffset = ^bus.snoopAddress[5:0];
  assign lineValid = hit && mesi != 2'b00;
  // READ (00) and RFO (10) are the only ops that pull dirty data out of an M line
  assign decideResult = !lineValid ? 2'b00 : (mesi == 2'b11 && !op[0]) ? 2'b10 : 2'b01;
  assign decideMesi = op == 2'b00 ? 2'b01 : 2'b00;
  assign decideError = lineValid && op[0] && (!op[1] || mesi[1]);
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = bus.snoopValid ? LOOKUP : IDLE;
      LOOKUP: nextState = bus.lookupDone ? DECIDE : LOOKUP;
      DECIDE: nextState = !lineValid ? RESPOND : decideResult == 2'b10 ? WRITEBACK : UPDATE;
      WRITEBACK: nextState = bus.wbReady ? UPDATE : WRITEBACK;
      UPDATE: nextState = RESPOND;
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      index <= '0;
      tag <= '0;
      hit <= 1'b0;
      way <= '0;
      mesi <= '0;
      newMesi <= '0;
      result <= '0;
      hitCount <= '0;
      hitmCount <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && bus.snoopValid) begin
        op <= bus.snoopOp;
        index <= bus.snoopAddress[6 +: indexBits];
        tag <= bus.snoopAddress[6 + indexBits +: tagBits];
      end
      if (state == LOOKUP && bus.lookupDone) begin
        hit <= bus.lookupHit;
        way <= bus.lookupWay;
        mesi <= bus.lookupMesi;
      end
      if (state == DECIDE) begin
        result <= decideResult;
        newMesi <= decideMesi;
      end
      if (state == RESPOND && result == 2'b01 && !(&hitCount)) hitCount <= hitCount + 1'b1;
      if (state == RESPOND && result == 2'b10 && !(&hitmCount)) hitmCount <= hitmCount + 1'b1;
    end
  end
  assign bus.snoopReady = state == IDLE && !reset;
  assign bus.lookupValid = state == LOOKUP;
  assign bus.lookupIndex = index;
  assign bus.lookupTag = tag;
  assign bus.updateValid = state == UPDATE;
  assign bus.updateIndex = index;
  assign bus.updateWay = way;
  assign bus.updateMesi = newMesi;
  assign bus.wbValid = state == WRITEBACK;
  assign bus.wbIndex = index;
  assign bus.wbWay = way;
  assign bus.resultValid = state == RESPOND;
  assign bus.snoopResult = state == RESPOND ? result : 2'b00;
  assign bus.protocolError = state == DECIDE && decideError;
  assign bus.hitCount = hitCount;
  assign bus.hitmCount = hitmCount;
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed snoops against a scoreboard of expected MESI outcomes; narrow counters reach saturation quickly.
module tb_snoop_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  snoop_responder_if #(.countBits(4)) bus();
  snoop_responder #(.countBits(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [1:0] res;
    int lat;
    int upd;
    logic [1:0] mesi;
    logic [2:0] way;
    int err;
    int wb;
    int look;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] mHit = 4'd0;
  logic [3:0] mHitm = 4'd0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic doSnoop(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                         input logic [2:0] way, input logic [1:0] mesi, input int wbWait, input logic hold);
    exp_t e;
    exp_t g;
    logic valid;
    logic wbOk;
    valid = hit && mesi != 2'd0;
    e.res = !valid ? 2'd0 : (mesi == 2'd3 && (op == 2'd0 || op == 2'd2)) ? 2'd2 : 2'd1;
    e.upd = valid ? 1 : 0;
    e.mesi = (valid && op == 2'd0) ? 2'd1 : 2'd0;
    e.way = valid ? way : 3'd0;
    e.err = (valid && (op == 2'd1 || (op == 2'd3 && mesi != 2'd1))) ? 1 : 0;
    e.wb = e.res == 2'd2 ? wbWait + 1 : 0;
    e.lat = e.res == 2'd0 ? 3 : e.res == 2'd1 ? 4 : 5 + wbWait;
    e.look = 1;
    sb.push_back(e);
    g = '{default: 0};
    wbOk = 1'b1;
    @(negedge clk);
    chk("snoopReady_idle", 32'(bus.snoopReady), 32'd1);
    bus.snoopValid = 1'b1;
    bus.snoopOp = op;
    bus.snoopAddress = addr;
    bus.wbReady = wbWait == 0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("lookupIndex", 32'(bus.lookupIndex), 32'(addr[19:6]));
        chk("lookupTag", 32'(bus.lookupTag), 32'(addr[31:20]));
        bus.lookupDone = 1'b1;
        bus.lookupHit = hit;
        bus.lookupWay = way;
        bus.lookupMesi = mesi;
        if (!hold) bus.snoopValid = 1'b0;
      end else begin
        bus.lookupDone = 1'b0;
      end
      if (bus.lookupValid) g.look++;
      if (bus.protocolError) g.err++;
      if (bus.updateValid) begin
        g.upd++;
        g.mesi = bus.updateMesi;
        g.way = bus.updateWay;
      end
      if (bus.wbValid) begin
        g.wb++;
        if (bus.wbIndex !== addr[19:6] || bus.wbWay !== way) wbOk = 1'b0;
        bus.wbReady = g.wb > wbWait;
      end
      if (bus.resultValid) begin
        g.res = bus.snoopResult;
        g.lat = k + 1;
        break;
      end
      @(posedge clk);
    end
    bus.snoopValid = 1'b0;
    bus.lookupDone = 1'b0;
    bus.wbReady = 1'b0;
    e = sb.pop_front();
    chk("snoopResult", 32'(g.res), 32'(e.res));
    chk("latency", 32'(g.lat), 32'(e.lat));
    chk("lookupCycles", 32'(g.look), 32'(e.look));
    chk("updateCount", 32'(g.upd), 32'(e.upd));
    chk("updateMesi", 32'(g.mesi), 32'(e.mesi));
    chk("updateWay", 32'(g.way), 32'(e.way));
    chk("protocolError", 32'(g.err), 32'(e.err));
    chk("wbCycles", 32'(g.wb), 32'(e.wb));
    chk("wbStable", 32'(wbOk), 32'd1);
    if (e.res == 2'd1 && mHit != 4'hF) mHit = mHit + 4'd1;
    if (e.res == 2'd2 && mHitm != 4'hF) mHitm = mHitm + 4'd1;
    @(posedge clk);
    @(negedge clk);
    chk("resultPulse", 32'(bus.resultValid), 32'd0);
    chk("hitCount", 32'(bus.hitCount), 32'(mHit));
    chk("hitmCount", 32'(bus.hitmCount), 32'(mHitm));
  endtask
  task automatic chkAllLow(input string tag);
    chk({tag, "_snoopReady"}, 32'(bus.snoopReady), 32'd0);
    chk({tag, "_lookupValid"}, 32'(bus.lookupValid), 32'd0);
    chk({tag, "_updateValid"}, 32'(bus.updateValid), 32'd0);
    chk({tag, "_wbValid"}, 32'(bus.wbValid), 32'd0);
    chk({tag, "_resultValid"}, 32'(bus.resultValid), 32'd0);
    chk({tag, "_snoopResult"}, 32'(bus.snoopResult), 32'd0);
    chk({tag, "_protocolError"}, 32'(bus.protocolError), 32'd0);
    chk({tag, "_hitCount"}, 32'(bus.hitCount), 32'd0);
    chk({tag, "_hitmCount"}, 32'(bus.hitmCount), 32'd0);
  endtask
  initial begin
    bus.snoopValid = 1'b0;
    bus.snoopOp = 2'd0;
    bus.snoopAddress = 32'd0;
    bus.lookupDone = 1'b0;
    bus.lookupHit = 1'b0;
    bus.lookupWay = 3'd0;
    bus.lookupMesi = 2'd0;
    bus.wbReady = 1'b0;
    #2;
    chkAllLow("reset");
    @(negedge clk);
    reset = 1'b0;
    doSnoop(2'd0, 32'h00ABC040, 1'b0, 3'd0, 2'd0, 0, 1'b0);
    doSnoop(2'd2, 32'h12345680, 1'b1, 3'd5, 2'd2, 0, 1'b0);
    doSnoop(2'd0, 32'hFEDCBA40, 1'b1, 3'd2, 2'd3, 3, 1'b0);
    doSnoop(2'd3, 32'h0F0F0FC0, 1'b1, 3'd7, 2'd3, 0, 1'b0);
    doSnoop(2'd1, 32'hA5A5A500, 1'b1, 3'd1, 2'd1, 0, 1'b0);
    doSnoop(2'd0, 32'h00001040, 1'b1, 3'd3, 2'd1, 0, 1'b1);
    doSnoop(2'd0, 32'h80000000, 1'b1, 3'd4, 2'd2, 0, 1'b0);
    doSnoop(2'd2, 32'h7FFFFFC0, 1'b1, 3'd6, 2'd3, 0, 1'b0);
    doSnoop(2'd2, 32'h00FF0040, 1'b1, 3'd0, 2'd0, 0, 1'b0);
    doSnoop(2'd3, 32'h33333340, 1'b1, 3'd2, 2'd1, 0, 1'b0);
    doSnoop(2'd3, 32'h44444480, 1'b1, 3'd5, 2'd2, 0, 1'b0);
    // abort a snoop while it sits in WRITEBACK
    @(negedge clk);
    bus.snoopValid = 1'b1;
    bus.snoopOp = 2'd0;
    bus.snoopAddress = 32'h55555540;
    bus.wbReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.snoopValid = 1'b0;
    bus.lookupDone = 1'b1;
    bus.lookupHit = 1'b1;
    bus.lookupWay = 3'd4;
    bus.lookupMesi = 2'd3;
    @(posedge clk);
    @(negedge clk);
    bus.lookupDone = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wbValid", 32'(bus.wbValid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chkAllLow("abort");
    mHit = 4'd0;
    mHitm = 4'd0;
    bus.wbReady = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("postAbort_snoopReady", 32'(bus.snoopReady), 32'd1);
      chk("postAbort_resultValid", 32'(bus.resultValid), 32'd0);
      chk("postAbort_updateValid", 32'(bus.updateValid), 32'd0);
    end
    bus.wbReady = 1'b0;
    for (int i = 0; i < 17; i++) doSnoop(2'd0, 32'(i) << 6, 1'b1, 3'(i), 2'd2, 0, 1'b0);
    chk("hitSaturated", 32'(bus.hitCount), 32'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
